imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, pipelined immediate extender for the RISC-V decode stage. It accepts a 32-bit instruction word, an immediate-format select and an opaque tag under a valid/ready handshake. It produces an XLEN-wide immediate plus an illegal-format flag through a 2-entry skid buffer. Compared with the single-cycle combinational extender, it adds U-type, XLEN generalisation, registered output, back-pressure and flush.

## Interface
- XLEN, 32 — immediate width; legal values 32 or 64.
- TAG_W, 32 — width of the passthrough tag (typically the PC); minimum 1.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; discards all buffered entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  block can accept an entry this cycle.
- in_instr  input  32  instruction word; only bits [31:7] are used.
- in_immsrc  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (macro only).
- in_tag  input  TAG_W  passthrough tag.
- out_valid  output  1  output entry present.
- out_ready  input  1  downstream accepts the output entry.
- out_imm  output  XLEN  extended immediate.
- out_illegal  output  1  in_immsrc was unsupported for this entry.
- out_tag  output  TAG_W  tag of this entry.

## Operation
- Immediate formats; sign bit s = instr[31], sign-extended to XLEN:
  - I: s-ext of instr[31:20].
  - S: s-ext of {instr[31:25], instr[11:7]}.
  - B: s-ext of {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - J: s-ext of {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - U: s-ext of {instr[31:12], 12'b0}.
- Unsupported in_immsrc (110, 111, or 101 without the macro): imm = 0 and illegal = 1. The entry still flows through normally.
- Extension is combinational on the input side. The result is captured into the buffer when the input handshake fires.
- Buffer: main register (drives out_*) plus skid register. States are by occupancy:
  - EMPTY.
  - ONE (main valid).
  - FULL (main and skid valid).
- Transitions, with acc = in_valid & in_ready and pop = out_valid & out_ready:
  - EMPTY + acc → ONE.
  - ONE + acc & !pop → FULL.
  - ONE + pop & !acc → EMPTY.
  - ONE + acc & pop → ONE; main is replaced by the new entry.
  - FULL + pop → ONE; skid moves to main.
  - FULL never accepts.
- Order is strictly FIFO. No entry is dropped or duplicated.
- flush = 1: next state is EMPTY, regardless of acc or pop in the same cycle. The entry offered that cycle is not accepted.
- in_ready = !skid_valid. It is a registered value with no combinational path from out_ready.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N; that is, out_valid is high in cycle N+1.
- Throughput: 1 entry/cycle when out_ready stays high.
- Back-pressure: in_ready falls one cycle after out_ready is first low with the main register occupied, once the skid register fills.
- out_* are stable while out_valid & !out_ready.
- Reset (asynchronous, any time including mid-transfer):
  - out_valid = 0, out_imm = 0, out_illegal = 0, out_tag = 0.
  - in_ready = 1; state EMPTY; skid contents cleared.
- After reset deassertion, the first acceptance can occur on the first rising edge.

## Configuration
- IMM_ZICSR_EN defined: in_immsrc 101 (Z-type) is legal. imm is zero-extension of instr[19:15] (the CSR uimm) and illegal = 0.
- IMM_ZICSR_EN undefined: 101 is treated as unsupported (imm = 0, illegal = 1). No Z-type logic is synthesised.

## Test plan
- I/S/B, XLEN=32:
  - instr 0xFFF00093 with immsrc 000 → imm 0xFFFFFFFF.
  - instr[31:25]=7'h7F, instr[11:7]=5'h1C with immsrc 001 → 0xFFFFFFFC.
  - instr[31]=1, instr[7]=1, [30:25]=6'h3F, [11:8]=4'hC with immsrc 010 → 0xFFFFFFF8.
  - All three produce illegal = 0.
- U/J at XLEN=64:
  - instr 0x800002B7 with immsrc 100 → 0xFFFFFFFF80000000.
  - instr 0x0080006F with immsrc 011 → 0x0000000000000008.
- Back-pressure: hold out_ready = 0 and offer tags 1, 2, 3 back-to-back.
  - in_ready = 0 after tag 2 is held; tag 3 stays offered.
  - Release out_ready → out_tag sequence 1, 2, 3 on consecutive cycles, none lost.
- Flush: in state FULL, assert flush with in_valid = 1 → next cycle out_valid = 0 and in_ready = 1; the offered entry never appears.
- Illegal/macro: immsrc 110 → imm 0, illegal 1. immsrc 101 with instr[19:15]=5'h1F → imm 0x1F and illegal 0 with IMM_ZICSR_EN, or imm 0 and illegal 1 without it.
- Reset mid-operation: assert reset asynchronously between edges in state FULL. Outputs go to 0 and in_ready to 1 immediately. After deassertion, a new entry returns its result 1 cycle after acceptance.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Pipelined RISC-V immediate extender. Each instruction word is decoded into
// an XLEN-wide immediate as it is accepted. The result is held in a 2-entry
// skid buffer (main + skid register) that provides valid/ready flow control
// on both sides.
//
// Parameters:
//   XLEN   immediate width (32 or 64)
//   TAG_W  width of the opaque passthrough tag (>= 1)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   flush        synchronous flush, empties the buffer
//   in_valid     upstream entry present
//   in_ready     block can accept an entry (registered, equals !skid valid)
//   in_instr     32-bit instruction word (bits [31:7] used)
//   in_immsrc    format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z
//   in_tag       passthrough tag
//   out_valid    output entry present
//   out_ready    downstream accepts the output entry
//   out_imm      extended immediate
//   out_illegal  in_immsrc was unsupported for this entry
//   out_tag      tag of this entry
//
// Configuration macro:
//   IMM_ZICSR_EN  when defined, format 101 (Z-type, CSR uimm) is legal and
//                 zero-extends instr[19:15]; otherwise 101 is unsupported.
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufState_e;

    bufState_e state_q, state_d;

    logic [XLEN-1:0]  mainImm_q, skidImm_q;
    logic             mainIll_q, skidIll_q;
    logic [TAG_W-1:0] mainTag_q, skidTag_q;

    logic [XLEN-1:0]  newImm;
    logic             newIll;
    logic             signBit;
    logic             acc;
    logic             pop;

    // The opcode field is never part of an immediate.
    logic unusedInstr;
    assign unusedInstr = ^in_instr[6:0];

    assign signBit = in_instr[31];

    // Input-side extension; the result is only captured on acceptance.
    always_comb begin
        newImm = '0;
        newIll = 1'b0;
        case (in_immsrc)
            3'b000: newImm = {{(XLEN-12){signBit}}, in_instr[31:20]};
            3'b001: newImm = {{(XLEN-12){signBit}}, in_instr[31:25], in_instr[11:7]};
            3'b010: newImm = {{(XLEN-12){signBit}}, in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            3'b011: newImm = {{(XLEN-20){signBit}}, in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            3'b100: newImm = {{(XLEN-31){signBit}}, in_instr[30:12], 12'b0};
`ifdef IMM_ZICSR_EN
            3'b101: newImm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
`endif
            default: begin
                newImm = '0;
                newIll = 1'b1;
            end
        endcase
    end

    // in_ready comes straight from the state register, so there is no
    // combinational path from out_ready back to the upstream stage.
    assign in_ready    = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign out_imm     = mainImm_q;
    assign out_illegal = mainIll_q;
    assign out_tag     = mainTag_q;

    assign acc = in_valid & in_ready & ~flush;
    assign pop = out_valid & out_ready;

    // Next-state logic for the occupancy FSM.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) state_d = ONE;
                ONE: begin
                    if (acc && !pop)      state_d = FULL;
                    else if (pop && !acc) state_d = EMPTY;
                end
                FULL:  if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and data registers. Flush also clears the buffered data so a
    // discarded entry leaves nothing behind on out_*.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            mainImm_q <= '0;
            mainIll_q <= 1'b0;
            mainTag_q <= '0;
            skidImm_q <= '0;
            skidIll_q <= 1'b0;
            skidTag_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                mainImm_q <= '0;
                mainIll_q <= 1'b0;
                mainTag_q <= '0;
                skidImm_q <= '0;
                skidIll_q <= 1'b0;
                skidTag_q <= '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (acc) begin
                            mainImm_q <= newImm;
                            mainIll_q <= newIll;
                            mainTag_q <= in_tag;
                        end
                    end
                    ONE: begin
                        if (acc && pop) begin
                            mainImm_q <= newImm;
                            mainIll_q <= newIll;
                            mainTag_q <= in_tag;
                        end else if (acc) begin
                            skidImm_q <= newImm;
                            skidIll_q <= newIll;
                            skidTag_q <= in_tag;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            mainImm_q <= skidImm_q;
                            mainIll_q <= skidIll_q;
                            mainTag_q <= skidTag_q;
                            skidImm_q <= '0;
                            skidIll_q <= 1'b0;
                            skidTag_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe
//
// Directed bench for imm_extend_pipe. Two instances share every input: one
// at XLEN=32 for the I/S/B formats and one at XLEN=64 for U/J. Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point, before
// the new inputs are applied.
// ---------------------------------------------------------------------------
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        inReady32, outValid32, outIll32;
    logic [31:0] outImm32, outTag32;
    logic        inReady64, outValid64, outIll64;
    logic [63:0] outImm64;
    logic [31:0] outTag64;

    int nChecks = 0;
    int nFails  = 0;

    imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (inReady32),
        .in_instr    (in_instr),
        .in_immsrc   (in_immsrc),
        .in_tag      (in_tag),
        .out_valid   (outValid32),
        .out_ready   (out_ready),
        .out_imm     (outImm32),
        .out_illegal (outIll32),
        .out_tag     (outTag32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (inReady64),
        .in_instr    (in_instr),
        .in_immsrc   (in_immsrc),
        .in_tag      (in_tag),
        .out_valid   (outValid64),
        .out_ready   (out_ready),
        .out_imm     (outImm64),
        .out_illegal (outIll64),
        .out_tag     (outTag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [2:0] src, input logic [31:0] tag,
                                 input logic oRdy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_immsrc = src;
        in_tag    = tag;
        out_ready = oRdy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic checkEmpty(input string name);
        checkOutput({name, "_valid32"}, {63'd0, outValid32}, 64'd0);
        checkOutput({name, "_ready32"}, {63'd0, inReady32}, 64'd1);
        checkOutput({name, "_imm32"}, {32'd0, outImm32}, 64'd0);
        checkOutput({name, "_ill32"}, {63'd0, outIll32}, 64'd0);
        checkOutput({name, "_tag32"}, {32'd0, outTag32}, 64'd0);
        checkOutput({name, "_valid64"}, {63'd0, outValid64}, 64'd0);
        checkOutput({name, "_imm64"}, outImm64, 64'd0);
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 1'b0);
        reset = 1'b1;
        #13;
        checkEmpty("reset");
        reset = 1'b0;

        // I-type, streamed back-to-back with out_ready high
        applyStimulus(1'b1, 32'hFFF00093, 3'b000, 32'd1, 1'b1, 1'b0);
        tick();
        checkOutput("i_valid", {63'd0, outValid32}, 64'd1);
        checkOutput("i_imm", {32'd0, outImm32}, 64'hFFFFFFFF);
        checkOutput("i_ill", {63'd0, outIll32}, 64'd0);
        checkOutput("i_tag", {32'd0, outTag32}, 64'd1);

        // S-type: [31:25]=7F, [11:7]=1C
        applyStimulus(1'b1, 32'hFE000E00, 3'b001, 32'd2, 1'b1, 1'b0);
        tick();
        checkOutput("s_imm", {32'd0, outImm32}, 64'hFFFFFFFC);
        checkOutput("s_ill", {63'd0, outIll32}, 64'd0);
        checkOutput("s_tag", {32'd0, outTag32}, 64'd2);

        // B-type: [31]=1, [7]=1, [30:25]=3F, [11:8]=C
        applyStimulus(1'b1, 32'hFE000C80, 3'b010, 32'd3, 1'b1, 1'b0);
        tick();
        checkOutput("b_imm", {32'd0, outImm32}, 64'hFFFFFFF8);
        checkOutput("b_ill", {63'd0, outIll32}, 64'd0);
        checkOutput("b_ready", {63'd0, inReady32}, 64'd1);

        // U-type
        applyStimulus(1'b1, 32'h800002B7, 3'b100, 32'd4, 1'b1, 1'b0);
        tick();
        checkOutput("u_imm64", outImm64, 64'hFFFFFFFF80000000);
        checkOutput("u_imm32", {32'd0, outImm32}, 64'h80000000);
        checkOutput("u_ill64", {63'd0, outIll64}, 64'd0);

        // J-type
        applyStimulus(1'b1, 32'h0080006F, 3'b011, 32'd5, 1'b1, 1'b0);
        tick();
        checkOutput("j_imm64", outImm64, 64'h0000000000000008);
        checkOutput("j_tag64", {32'd0, outTag64}, 64'd5);

        // Unsupported format 110
        applyStimulus(1'b1, 32'hFFFFFFFF, 3'b110, 32'd6, 1'b1, 1'b0);
        tick();
        checkOutput("f6_imm", {32'd0, outImm32}, 64'd0);
        checkOutput("f6_ill", {63'd0, outIll32}, 64'd1);
        checkOutput("f6_valid", {63'd0, outValid32}, 64'd1);

        // Z-type, instr[19:15]=1F
        applyStimulus(1'b1, 32'h000F8073, 3'b101, 32'd7, 1'b1, 1'b0);
        tick();
`ifdef IMM_ZICSR_EN
        checkOutput("z_imm64", outImm64, 64'h1F);
        checkOutput("z_ill64", {63'd0, outIll64}, 64'd0);
`else
        checkOutput("z_imm64", outImm64, 64'd0);
        checkOutput("z_ill64", {63'd0, outIll64}, 64'd1);
`endif
        checkOutput("z_tag", {32'd0, outTag32}, 64'd7);

        applyStimulus(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_valid", {63'd0, outValid32}, 64'd0);

        // Back-pressure: tags 1,2,3 offered with out_ready low
        applyStimulus(1'b1, 32'h00100093, 3'b000, 32'd1, 1'b0, 1'b0);
        tick();
        checkOutput("bp1_valid", {63'd0, outValid32}, 64'd1);
        checkOutput("bp1_ready", {63'd0, inReady32}, 64'd1);
        checkOutput("bp1_tag", {32'd0, outTag32}, 64'd1);
        applyStimulus(1'b1, 32'h00200093, 3'b000, 32'd2, 1'b0, 1'b0);
        tick();
        checkOutput("bp2_ready", {63'd0, inReady32}, 64'd0);
        checkOutput("bp2_tag", {32'd0, outTag32}, 64'd1);
        applyStimulus(1'b1, 32'h00300093, 3'b000, 32'd3, 1'b0, 1'b0);
        tick();
        checkOutput("bp3_ready", {63'd0, inReady32}, 64'd0);
        checkOutput("bp3_tag_stable", {32'd0, outTag32}, 64'd1);
        checkOutput("bp3_imm_stable", {32'd0, outImm32}, 64'd1);
        applyStimulus(1'b1, 32'h00300093, 3'b000, 32'd3, 1'b1, 1'b0);
        tick();
        checkOutput("rel_tag2", {32'd0, outTag32}, 64'd2);
        checkOutput("rel_imm2", {32'd0, outImm32}, 64'd2);
        checkOutput("rel_ready", {63'd0, inReady32}, 64'd1);
        tick();
        checkOutput("rel_tag3", {32'd0, outTag32}, 64'd3);
        checkOutput("rel_valid3", {63'd0, outValid32}, 64'd1);
        applyStimulus(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("rel_empty", {63'd0, outValid32}, 64'd0);

        // Flush while FULL with an entry offered
        applyStimulus(1'b1, 32'h0, 3'b000, 32'd21, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0, 3'b000, 32'd22, 1'b0, 1'b0);
        tick();
        checkOutput("fl_full_ready", {63'd0, inReady32}, 64'd0);
        applyStimulus(1'b1, 32'h0, 3'b000, 32'd23, 1'b0, 1'b1);
        tick();
        checkOutput("fl_valid", {63'd0, outValid32}, 64'd0);
        checkOutput("fl_ready", {63'd0, inReady32}, 64'd1);
        applyStimulus(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_after_valid", {63'd0, outValid32}, 64'd0);

        // Flush while ONE: the entry offered alongside flush is not taken
        applyStimulus(1'b1, 32'h0, 3'b000, 32'd24, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0, 3'b000, 32'd25, 1'b1, 1'b1);
        tick();
        checkOutput("fl1_valid", {63'd0, outValid32}, 64'd0);
        applyStimulus(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("fl1_after_valid", {63'd0, outValid32}, 64'd0);

        // Asynchronous reset between edges while FULL
        applyStimulus(1'b1, 32'h00100093, 3'b000, 32'd31, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00200093, 3'b000, 32'd32, 1'b0, 1'b0);
        tick();
        checkOutput("rst_pre_ready", {63'd0, inReady32}, 64'd0);
        applyStimulus(1'b0, 32'h0, 3'b000, 32'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkEmpty("midrst");
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 32'hFFF00093, 3'b000, 32'd33, 1'b1, 1'b0);
        tick();
        checkOutput("postrst_valid", {63'd0, outValid32}, 64'd1);
        checkOutput("postrst_tag", {32'd0, outTag32}, 64'd33);
        checkOutput("postrst_imm", {32'd0, outImm32}, 64'hFFFFFFFF);
        applyStimulus(1'b0, 32'h0, 3'b000, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("postrst_empty", {63'd0, outValid32}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
